// File: rtl/zet_wb_front_back_arbiter_pkg.sv
// Shared encodings and bus widths for the front/back Wishbone arbiter.
package zet_wb_arb_pkg;

    localparam int unsigned ADR_W = 19;
    localparam int unsigned DAT_W = 16;
    localparam int unsigned SEL_W = 2;

    // State encoding doubles as the gnt_o owner code.
    typedef enum logic [1:0] {
        ARB_IDLE = 2'b00,
        ARB_INS  = 2'b01,
        ARB_DAT  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/zet_wb_front_back_arbiter_if.sv
// Bundle of the instruction, data and shared Wishbone signals around the arbiter.
interface zet_wb_front_back_arbiter_if;
    import zet_wb_arb_pkg::*;

    logic [ADR_W-1:0] ins_adr_i;
    logic [SEL_W-1:0] ins_sel_i;
    logic             ins_cyc_i;
    logic             ins_stb_i;
    logic [DAT_W-1:0] ins_dat_o;
    logic             ins_ack_o;

    logic [ADR_W-1:0] dat_adr_i;
    logic [DAT_W-1:0] dat_dat_i;
    logic [SEL_W-1:0] dat_sel_i;
    logic             dat_we_i;
    logic             dat_tga_i;
    logic             dat_cyc_i;
    logic             dat_stb_i;
    logic [DAT_W-1:0] dat_dat_o;
    logic             dat_ack_o;

    logic [ADR_W-1:0] wb_adr_o;
    logic [DAT_W-1:0] wb_dat_o;
    logic [DAT_W-1:0] wb_dat_i;
    logic [SEL_W-1:0] wb_sel_o;
    logic             wb_we_o;
    logic             wb_tga_o;
    logic             wb_cyc_o;
    logic             wb_stb_o;
    logic             wb_ack_i;

    // Arbiter side: it is the master on the shared bus.
    modport master (
        input  ins_adr_i, ins_sel_i, ins_cyc_i, ins_stb_i,
        output ins_dat_o, ins_ack_o,
        input  dat_adr_i, dat_dat_i, dat_sel_i, dat_we_i, dat_tga_i, dat_cyc_i, dat_stb_i,
        output dat_dat_o, dat_ack_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i
    );

    // Environment side: requesters plus the interconnect slave.
    modport slave (
        output ins_adr_i, ins_sel_i, ins_cyc_i, ins_stb_i,
        input  ins_dat_o, ins_ack_o,
        output dat_adr_i, dat_dat_i, dat_sel_i, dat_we_i, dat_tga_i, dat_cyc_i, dat_stb_i,
        input  dat_dat_o, dat_ack_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_tga_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i
    );

endinterface

// File: rtl/zet_wb_front_back_arbiter.sv
// Per-tenure arbiter of one Wishbone bus between instruction prefetch and data masters;
// data has priority, bounded by a starvation counter that guarantees instruction a turn.
module zet_wb_front_back_arbiter
    import zet_wb_arb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4,
    parameter int unsigned CNT_W        = 3
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    zet_wb_front_back_arbiter_if.master bus,
    output logic [1:0]                  gnt_o
);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
    logic             starve_hit;

    assign starve_hit = (STARVE_LIMIT != 0) && (starve_cnt_q == CNT_W'(STARVE_LIMIT));

    function automatic arb_state_e pick(input logic ins_req, input logic dat_req,
                                        input logic hit);
        if (ins_req && dat_req) return hit ? ARB_INS : ARB_DAT;
        if (dat_req)            return ARB_DAT;
        if (ins_req)            return ARB_INS;
        return ARB_IDLE;
    endfunction

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ARB_IDLE;
            starve_cnt_q <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    // Next owner; a releasing owner re-arbitrates in the same edge with its own request masked.
    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        unique case (state_q)
            ARB_INS: if (!bus.ins_cyc_i) state_d = pick(1'b0, bus.dat_cyc_i, starve_hit);
            ARB_DAT: if (!bus.dat_cyc_i) state_d = pick(bus.ins_cyc_i, 1'b0, starve_hit);
            default: state_d = pick(bus.ins_cyc_i, bus.dat_cyc_i, starve_hit);
        endcase

        if (state_d == ARB_INS && state_q != ARB_INS) begin
            starve_cnt_d = '0;
        end else if (state_d == ARB_DAT && state_q != ARB_DAT && bus.ins_cyc_i) begin
            starve_cnt_d = starve_hit ? starve_cnt_q : starve_cnt_q + CNT_W'(1);
        end else if (state_q == ARB_IDLE && !bus.ins_cyc_i) begin
            starve_cnt_d = '0;
        end
    end

    // Bus mux and ack routing, decoded from the registered owner.
    always_comb begin
        bus.wb_adr_o  = '0;
        bus.wb_dat_o  = '0;
        bus.wb_sel_o  = '0;
        bus.wb_we_o   = 1'b0;
        bus.wb_tga_o  = 1'b0;
        bus.wb_cyc_o  = 1'b0;
        bus.wb_stb_o  = 1'b0;
        bus.ins_ack_o = 1'b0;
        bus.dat_ack_o = 1'b0;
        bus.ins_dat_o = bus.wb_dat_i;
        bus.dat_dat_o = bus.wb_dat_i;
        unique case (state_q)
            ARB_INS: begin
                bus.wb_adr_o  = bus.ins_adr_i;
                bus.wb_sel_o  = bus.ins_sel_i;
                bus.wb_cyc_o  = bus.ins_cyc_i;
                bus.wb_stb_o  = bus.ins_cyc_i & bus.ins_stb_i;
                bus.ins_ack_o = bus.wb_ack_i & bus.ins_stb_i;
            end
            ARB_DAT: begin
                bus.wb_adr_o  = bus.dat_adr_i;
                bus.wb_dat_o  = bus.dat_dat_i;
                bus.wb_sel_o  = bus.dat_sel_i;
                bus.wb_we_o   = bus.dat_we_i;
                bus.wb_tga_o  = bus.dat_tga_i;
                bus.wb_cyc_o  = bus.dat_cyc_i;
                bus.wb_stb_o  = bus.dat_cyc_i & bus.dat_stb_i;
                bus.dat_ack_o = bus.wb_ack_i & bus.dat_stb_i;
            end
            default: ;
        endcase
    end

    assign gnt_o = state_q;

endmodule

// File: tb/tb_zet_wb_front_back_arbiter.sv
// Scenario bench for the front/back arbiter; acks are scoreboarded by a negedge monitor.
module tb_zet_wb_front_back_arbiter;
    import zet_wb_arb_pkg::*;

    localparam int unsigned LIMIT = 4;

    typedef struct packed {
        logic [1:0]  port;
        logic [15:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] gnt;
    int checks = 0;
    int errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;
    exp_t push_e;

    always #5 clk = ~clk;

    zet_wb_front_back_arbiter_if bus ();

    zet_wb_front_back_arbiter #(.STARVE_LIMIT(LIMIT), .CNT_W(3)) dut (
        .clk_i(clk), .rst_i(rst), .bus(bus), .gnt_o(gnt)
    );

    // Every delivered ack must match the oldest expected one in port and data.
    always @(negedge clk) begin
        if (!rst && (bus.ins_ack_o || bus.dat_ack_o)) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ack_unexpected: ins_ack=%b dat_ack=%b, required none",
                         bus.ins_ack_o, bus.dat_ack_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({bus.dat_ack_o, bus.ins_ack_o} !== mon_e.port ||
                    (bus.ins_ack_o ? bus.ins_dat_o : bus.dat_dat_o) !== mon_e.data) begin
                    errors++;
                    $display("FAIL ack_scoreboard: port=%b ins_dat=%h dat_dat=%h, required port=%b data=%h",
                             {bus.dat_ack_o, bus.ins_ack_o}, bus.ins_dat_o, bus.dat_dat_o,
                             mon_e.port, mon_e.data);
                end
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        bus.ins_adr_i = '0; bus.ins_sel_i = '0; bus.ins_cyc_i = 0; bus.ins_stb_i = 0;
        bus.dat_adr_i = '0; bus.dat_dat_i = '0; bus.dat_sel_i = '0; bus.dat_we_i = 0;
        bus.dat_tga_i = 0;  bus.dat_cyc_i = 0;  bus.dat_stb_i = 0;
        bus.wb_dat_i  = '0; bus.wb_ack_i  = 0;
    endtask

    // One slave ack beat; the caller sets any cyc drop that coincides with it.
    task automatic ack_beat(input logic [1:0] port, input logic [15:0] d);
        bus.wb_dat_i = d;
        bus.wb_ack_i = 1'b1;
        push_e.port = port;
        push_e.data = d;
        exp_q.push_back(push_e);
        tick();
        bus.wb_ack_i = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        tick(); tick();
        checks++;
        if ({gnt, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o} !== 5'b0 || bus.wb_adr_o !== 19'h0) begin
            errors++;
            $display("FAIL reset_outputs: gnt=%b cyc=%b stb=%b we=%b adr=%h, required all 0",
                     gnt, bus.wb_cyc_o, bus.wb_stb_o, bus.wb_we_o, bus.wb_adr_o);
        end
        rst = 1'b0;
        bus.dat_cyc_i = 1; bus.dat_stb_i = 1; bus.dat_adr_i = 19'h7_0001;
        tick();
        checks++;
        if (gnt !== ARB_DAT || bus.wb_cyc_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_pre_grant: gnt=%b cyc=%b, required 10 1", gnt, bus.wb_cyc_o);
        end
        rst = 1'b1;
        tick();
        checks++;
        if (gnt !== ARB_IDLE || bus.wb_cyc_o !== 1'b0 || bus.wb_stb_o !== 1'b0 ||
            dut.starve_cnt_q !== 3'd0) begin
            errors++;
            $display("FAIL reset_mid_cycle: gnt=%b cyc=%b stb=%b cnt=%0d, required 00 0 0 0",
                     gnt, bus.wb_cyc_o, bus.wb_stb_o, dut.starve_cnt_q);
        end
        clear_inputs();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_simultaneous_and_routing;
        bus.ins_cyc_i = 1; bus.ins_stb_i = 1; bus.ins_adr_i = 19'h5_5555; bus.ins_sel_i = 2'b11;
        bus.dat_cyc_i = 1; bus.dat_stb_i = 1; bus.dat_adr_i = 19'h0_1234; bus.dat_sel_i = 2'b10;
        bus.dat_tga_i = 1; bus.dat_dat_i = 16'h7777;
        tick();
        checks++;
        if (gnt !== ARB_DAT || bus.wb_adr_o !== 19'h0_1234 || bus.wb_sel_o !== 2'b10 ||
            bus.wb_tga_o !== 1'b1 || bus.wb_stb_o !== 1'b1 || bus.wb_dat_o !== 16'h7777) begin
            errors++;
            $display("FAIL simul_dat_wins: gnt=%b adr=%h sel=%b tga=%b stb=%b dat=%h, required 10 01234 10 1 1 7777",
                     gnt, bus.wb_adr_o, bus.wb_sel_o, bus.wb_tga_o, bus.wb_stb_o, bus.wb_dat_o);
        end
        checks++;
        if (dut.starve_cnt_q !== 3'd1) begin
            errors++;
            $display("FAIL simul_cnt: cnt=%0d, required 1", dut.starve_cnt_q);
        end
        bus.dat_cyc_i = 0;
        bus.wb_dat_i = 16'h1111; bus.wb_ack_i = 1;
        push_e.port = ARB_DAT; push_e.data = 16'h1111;
        exp_q.push_back(push_e);
        #1;
        checks++;
        if (bus.ins_ack_o !== 1'b0 || bus.dat_ack_o !== 1'b1) begin
            errors++;
            $display("FAIL simul_ack_owner: ins_ack=%b dat_ack=%b, required 0 1",
                     bus.ins_ack_o, bus.dat_ack_o);
        end
        tick();
        bus.wb_ack_i = 0; bus.dat_stb_i = 0; bus.dat_we_i = 1;
        #1;
        checks++;
        if (gnt !== ARB_INS || dut.starve_cnt_q !== 3'd0 || bus.wb_adr_o !== 19'h5_5555 ||
            bus.wb_we_o !== 1'b0 || bus.wb_tga_o !== 1'b0 || bus.wb_dat_o !== 16'h0) begin
            errors++;
            $display("FAIL handover_ins: gnt=%b cnt=%0d adr=%h we=%b tga=%b dat=%h, required 01 0 55555 0 0 0000",
                     gnt, dut.starve_cnt_q, bus.wb_adr_o, bus.wb_we_o, bus.wb_tga_o, bus.wb_dat_o);
        end
        bus.ins_cyc_i = 0;
        bus.wb_dat_i = 16'hBEEF; bus.wb_ack_i = 1;
        push_e.port = ARB_INS; push_e.data = 16'hBEEF;
        exp_q.push_back(push_e);
        #1;
        checks++;
        if (bus.ins_ack_o !== 1'b1 || bus.ins_dat_o !== 16'hBEEF || bus.dat_ack_o !== 1'b0 ||
            bus.wb_we_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_routing_ins: ins_ack=%b ins_dat=%h dat_ack=%b we=%b, required 1 beef 0 0",
                     bus.ins_ack_o, bus.ins_dat_o, bus.dat_ack_o, bus.wb_we_o);
        end
        tick();
        clear_inputs();
        #1;
        checks++;
        if (gnt !== ARB_IDLE) begin
            errors++;
            $display("FAIL release_idle: gnt=%b, required 00", gnt);
        end
    endtask

    task automatic test_spurious_ack;
        bus.wb_dat_i = 16'hDEAD; bus.wb_ack_i = 1;
        #1;
        checks++;
        if (bus.ins_ack_o !== 1'b0 || bus.dat_ack_o !== 1'b0) begin
            errors++;
            $display("FAIL spurious_ack: ins_ack=%b dat_ack=%b, required 0 0",
                     bus.ins_ack_o, bus.dat_ack_o);
        end
        tick();
        bus.wb_ack_i = 0;
        checks++;
        if (gnt !== ARB_IDLE) begin
            errors++;
            $display("FAIL spurious_state: gnt=%b, required 00", gnt);
        end
    endtask

    // The instruction master withdraws on each data release edge and re-requests in IDLE,
    // so every contested arbitration runs from IDLE and the counter accumulates.
    task automatic test_starvation;
        int model_cnt;
        logic [1:0] exp_gnt;
        model_cnt = 0;
        for (int i = 0; i < 5; i++) begin
            bus.ins_cyc_i = 1; bus.ins_stb_i = 1; bus.ins_adr_i = 19'h1_0000 + 19'(i);
            bus.dat_cyc_i = 1; bus.dat_stb_i = 1; bus.dat_adr_i = 19'h2_0000 + 19'(i);
            exp_gnt = (model_cnt == int'(LIMIT)) ? ARB_INS : ARB_DAT;
            if (exp_gnt == ARB_DAT) model_cnt = (model_cnt == int'(LIMIT)) ? model_cnt : model_cnt + 1;
            else model_cnt = 0;
            tick();
            checks++;
            if (gnt !== exp_gnt || dut.starve_cnt_q !== 3'(model_cnt)) begin
                errors++;
                $display("FAIL starve_arb_%0d: gnt=%b cnt=%0d, required %b %0d",
                         i, gnt, dut.starve_cnt_q, exp_gnt, model_cnt);
            end
            bus.ins_cyc_i = 0; bus.dat_cyc_i = 0;
            ack_beat(exp_gnt, 16'hA000 + 16'(i));
            bus.ins_stb_i = 0; bus.dat_stb_i = 0;
            checks++;
            if (gnt !== ARB_IDLE) begin
                errors++;
                $display("FAIL starve_release_%0d: gnt=%b, required 00", i, gnt);
            end
        end
        tick();
    endtask

    task automatic test_locked_rmw;
        bus.dat_cyc_i = 1; bus.dat_stb_i = 1; bus.dat_we_i = 0; bus.dat_adr_i = 19'h0_0ABC;
        bus.ins_cyc_i = 1; bus.ins_stb_i = 1; bus.ins_adr_i = 19'h3_0000;
        tick();
        checks++;
        if (gnt !== ARB_DAT || bus.wb_we_o !== 1'b0 || bus.wb_adr_o !== 19'h0_0ABC) begin
            errors++;
            $display("FAIL rmw_read_grant: gnt=%b we=%b adr=%h, required 10 0 00abc",
                     gnt, bus.wb_we_o, bus.wb_adr_o);
        end
        ack_beat(ARB_DAT, 16'h0A0A);
        bus.dat_stb_i = 0;
        #1;
        checks++;
        if (gnt !== ARB_DAT || bus.wb_cyc_o !== 1'b1 || bus.wb_stb_o !== 1'b0) begin
            errors++;
            $display("FAIL rmw_locked_gap: gnt=%b cyc=%b stb=%b, required 10 1 0",
                     gnt, bus.wb_cyc_o, bus.wb_stb_o);
        end
        tick();
        bus.dat_stb_i = 1; bus.dat_we_i = 1; bus.dat_dat_i = 16'h5A5A;
        #1;
        checks++;
        if (gnt !== ARB_DAT || bus.wb_we_o !== 1'b1 || bus.wb_dat_o !== 16'h5A5A) begin
            errors++;
            $display("FAIL rmw_write_beat: gnt=%b we=%b dat=%h, required 10 1 5a5a",
                     gnt, bus.wb_we_o, bus.wb_dat_o);
        end
        bus.dat_cyc_i = 0;
        ack_beat(ARB_DAT, 16'h0000);
        bus.dat_stb_i = 0; bus.dat_we_i = 0;
        checks++;
        if (gnt !== ARB_INS || bus.wb_adr_o !== 19'h3_0000) begin
            errors++;
            $display("FAIL rmw_then_ins: gnt=%b adr=%h, required 01 30000", gnt, bus.wb_adr_o);
        end
        bus.ins_cyc_i = 0;
        ack_beat(ARB_INS, 16'hC0DE);
        clear_inputs();
        checks++;
        if (gnt !== ARB_IDLE) begin
            errors++;
            $display("FAIL rmw_final_idle: gnt=%b, required 00", gnt);
        end
    endtask

    initial begin
        test_reset();
        test_simultaneous_and_routing();
        test_spurious_ack();
        test_starvation();
        test_locked_rmw();
        tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d acks outstanding, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
